// File: rtl/i2s_receiver.sv
// I2S receiver: synchronises bit_clk/frame_clk/data into clk, deserialises
// left/right words with the one-bit I2S delay, and flags slot-length errors.
module i2s_receiver #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_clk,
  input  logic             frame_clk,
  input  logic             data,
  output logic [WIDTH-1:0] sample_left,
  output logic [WIDTH-1:0] sample_right,
  output logic             sample_valid,
  output logic             frame_err,
  output logic             locked
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic {SYNC = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic             bck_s1, bck_s2, bck_d;
  logic             lr_s1, lr_s2;
  logic             dat_s1, dat_s2;
  logic             lr_prev;
  logic             left_ok;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] stage;

  logic             bit_rise_c;
  logic             trans_c;
  logic             last_c;
  logic [WIDTH-1:0] word_c;

  // Two-flop synchronisers plus one extra bit_clk stage for rise detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bck_s1 <= 1'b0;
      bck_s2 <= 1'b0;
      bck_d  <= 1'b0;
      lr_s1  <= 1'b0;
      lr_s2  <= 1'b0;
      dat_s1 <= 1'b0;
      dat_s2 <= 1'b0;
    end else begin
      bck_s1 <= bit_clk;
      bck_s2 <= bck_s1;
      bck_d  <= bck_s2;
      lr_s1  <= frame_clk;
      lr_s2  <= lr_s1;
      dat_s1 <= data;
      dat_s2 <= dat_s1;
    end
  end

  assign bit_rise_c = bck_s2 & ~bck_d;
  assign trans_c    = lr_s2 != lr_prev;
  assign last_c     = bit_cnt == CW'(WIDTH - 1);
  // Word as it stands including the bit arriving on this edge
  assign word_c     = {shift[WIDTH-2:0], dat_s2};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= SYNC;
      locked       <= 1'b0;
      sample_left  <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      bit_cnt      <= '0;
      left_ok      <= 1'b0;
      shift        <= '0;
      stage        <= '0;
      lr_prev      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      if (bit_rise_c) begin
        shift   <= word_c;
        lr_prev <= lr_s2;
        if (trans_c) begin
          bit_cnt <= '0;
        end else if (bit_cnt != CW'(WIDTH)) begin
          bit_cnt <= bit_cnt + CW'(1);
        end
        case (state)
          SYNC: begin
            // Align only on the start of a left slot
            if (trans_c && !lr_s2) begin
              state  <= RUN;
              locked <= 1'b1;
            end
          end
          RUN: begin
            if (trans_c && last_c) begin
              if (!lr_prev) begin
                stage   <= word_c;
                left_ok <= 1'b1;
              end else if (left_ok) begin
                sample_left  <= stage;
                sample_right <= word_c;
                sample_valid <= 1'b1;
                left_ok      <= 1'b0;
              end
            end else if (trans_c || last_c) begin
              // Slot too short (early transition) or too long (missing one)
              frame_err <= 1'b1;
              left_ok   <= 1'b0;
              state     <= SYNC;
              locked    <= 1'b0;
            end
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

endmodule
